// File: rtl/fp16_pkg.sv
// Shared types and constants for the fp16 -> int16 converter.
// Holds the fp16 field widths, int16 limits, FSM state type and operand classifier.
package fp16_pkg;

   localparam int FP16_EXP_W       = 5;
   localparam int FP16_FRAC_W      = 10;
   localparam int FP16_BIAS        = 15;
   localparam int FP16_EXP_SPECIAL = 31;

   localparam logic [15:0] INT16_MAX = 16'h7FFF;
   localparam logic [15:0] INT16_MIN = 16'h8000;

   // Biased-exponent boundaries of the shift windows:
   // e < 14 rounds to zero, 14..24 shifts right, 25..29 shifts left,
   // 30 and above no longer fits in int16.
   localparam logic [4:0] EXP_RSH_LO = 5'(FP16_BIAS - 1);
   localparam logic [4:0] EXP_LSH_LO = 5'(FP16_BIAS + FP16_FRAC_W);
   localparam logic [4:0] EXP_SAT_LO = 5'(FP16_BIAS + 15);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      ROUND,
      DONE
   } fp2int_state_t;

   typedef enum logic [2:0] {
      CLS_NORM,
      CLS_ZERO,
      CLS_INF,
      CLS_NAN,
      CLS_SAT,
      CLS_MIN
   } fp2int_class_t;

   typedef struct packed {
      fp2int_class_t cls;
      logic          left;
      logic [3:0]    count;
   } fp2int_plan_t;

   // Decide the result class, shift direction and shift distance.
   function automatic fp2int_plan_t fp2int_classify(input logic [15:0] v);
      fp2int_plan_t p;
      logic [4:0]   e;
      logic [9:0]   f;
      e       = v[14:10];
      f       = v[9:0];
      p.cls   = CLS_ZERO;
      p.left  = 1'b0;
      p.count = 4'd0;
      if (e == 5'(FP16_EXP_SPECIAL)) begin
         p.cls = (f == 10'd0) ? CLS_INF : CLS_NAN;
      end else if (e < EXP_RSH_LO) begin
         p.cls = CLS_ZERO;
      end else if (e >= EXP_SAT_LO) begin
         // -32768.0 is the only value at this exponent that fits.
         if (v[15] && e == EXP_SAT_LO && f == 10'd0)
            p.cls = CLS_MIN;
         else
            p.cls = CLS_SAT;
      end else if (e >= EXP_LSH_LO) begin
         p.cls   = CLS_NORM;
         p.left  = 1'b1;
         p.count = 4'(e - EXP_LSH_LO);
      end else begin
         p.cls   = CLS_NORM;
         p.count = 4'(EXP_LSH_LO - e);
      end
      return p;
   endfunction

endpackage

// File: rtl/complimenter_2.sv
// Two's-complement negation of a WIDTH-bit word.
// Ports: a (operand), y (-a modulo 2**WIDTH).
module complimenter_2 #(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] a,
   output logic [WIDTH-1:0] y
);

   assign y = ~a + {{(WIDTH-1){1'b0}}, 1'b1};

endmodule

// File: rtl/fp2int_round_sat.sv
// Combinational rounding, sign application and saturation for fp16 -> int16.
// Ports: mag/guard/sticky/sign/cls in; r and ALU flags (negative, cout, overflow, zero) out.
// Macro FP2INT_RNE_EN: defined = round-to-nearest-even, undefined = truncate toward zero.
module fp2int_round_sat
   import fp16_pkg::*;
(
   input  logic [15:0]   mag,
   input  logic          guard,
   input  logic          sticky,
   input  logic          sign,
   input  fp2int_class_t cls,
   output logic [15:0]   r,
   output logic          negative,
   output logic          cout,
   output logic          overflow,
   output logic          zero
);

   logic        inc;
   logic [15:0] mag_rnd;
   logic [15:0] mag_neg;

`ifdef FP2INT_RNE_EN
   // Round up above half, or at exactly half when the kept LSB is odd.
   assign inc = guard & (sticky | mag[0]);
`else
   logic unused_gs;
   assign unused_gs = guard | sticky;
   assign inc       = 1'b0;
`endif

   // Non-saturated magnitudes top out at 32752, so this add cannot wrap.
   assign mag_rnd = mag + {15'd0, inc};

   complimenter_2 #(
      .WIDTH(16)
   ) u_neg (
      .a(mag_rnd),
      .y(mag_neg)
   );

   always_comb begin
      r        = 16'd0;
      overflow = 1'b0;
      unique case (cls)
         CLS_NORM: r = sign ? mag_neg : mag_rnd;
         CLS_ZERO: r = 16'd0;
         CLS_INF: begin
            r        = sign ? INT16_MIN : INT16_MAX;
            overflow = 1'b1;
         end
         CLS_NAN: begin
            r        = 16'd0;
            overflow = 1'b1;
         end
         CLS_SAT: begin
            r        = sign ? INT16_MIN : INT16_MAX;
            overflow = 1'b1;
         end
         CLS_MIN: r = INT16_MIN;
         default: r = 16'd0;
      endcase
   end

   assign negative = r[15];
   assign zero     = (r == 16'd0);
   assign cout     = 1'b0;

endmodule

// File: rtl/fp16_to_int_converter.sv
// Multi-cycle fp16 -> int16 converter: serial shifter with guard/sticky, rounding, saturation.
// Ports: clk, rst (sync, active-high); in_valid/in_ready/x in; out_valid/out_ready/r + flags out.
// Parameter SHIFT_STEP (1, 2 or 4) sets bit positions moved per SHIFT cycle.
// Macro FP2INT_RNE_EN: defined = round-to-nearest-even, undefined = truncate toward zero.
module fp16_to_int_converter
   import fp16_pkg::*;
#(
   parameter int SHIFT_STEP = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] x,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] r,
   output logic        negative,
   output logic        cout,
   output logic        overflow,
   output logic        zero
);

   localparam logic [3:0] STEP = 4'(SHIFT_STEP);

   fp2int_state_t state;
   fp2int_class_t cls_q;
   fp2int_plan_t  plan;

   logic        sign_q;
   logic        left_q;
   logic [3:0]  count_q;
   logic [15:0] mag_q;
   logic        guard_q;
   logic        sticky_q;

   logic [3:0]  amt;
   logic [15:0] mag_n;
   logic        guard_n;
   logic        sticky_n;

   logic [15:0] rnd_r;
   logic        rnd_neg;
   logic        rnd_cout;
   logic        rnd_ovf;
   logic        rnd_zero;

   logic [15:0] r_q;
   logic        neg_q;
   logic        cout_q;
   logic        ovf_q;
   logic        zero_q;

   assign plan = fp2int_classify(x);

   // One SHIFT cycle: move up to SHIFT_STEP places. On right shifts the
   // previous guard drops into sticky and the newest lost bit becomes guard.
   always_comb begin
      amt      = (count_q > STEP) ? STEP : count_q;
      mag_n    = mag_q;
      guard_n  = guard_q;
      sticky_n = sticky_q;
      for (int i = 0; i < SHIFT_STEP; i++) begin
         if (4'(i) < amt) begin
            if (left_q) begin
               mag_n = {mag_n[14:0], 1'b0};
            end else begin
               sticky_n = sticky_n | guard_n;
               guard_n  = mag_n[0];
               mag_n    = {1'b0, mag_n[15:1]};
            end
         end
      end
   end

   fp2int_round_sat u_round (
      .mag     (mag_q),
      .guard   (guard_q),
      .sticky  (sticky_q),
      .sign    (sign_q),
      .cls     (cls_q),
      .r       (rnd_r),
      .negative(rnd_neg),
      .cout    (rnd_cout),
      .overflow(rnd_ovf),
      .zero    (rnd_zero)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         cls_q    <= CLS_ZERO;
         sign_q   <= 1'b0;
         left_q   <= 1'b0;
         count_q  <= 4'd0;
         mag_q    <= 16'd0;
         guard_q  <= 1'b0;
         sticky_q <= 1'b0;
         r_q      <= 16'd0;
         neg_q    <= 1'b0;
         cout_q   <= 1'b0;
         ovf_q    <= 1'b0;
         zero_q   <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (in_valid) begin
                  sign_q   <= x[15];
                  cls_q    <= plan.cls;
                  left_q   <= plan.left;
                  count_q  <= plan.count;
                  mag_q    <= {5'd0, 1'b1, x[9:0]};
                  guard_q  <= 1'b0;
                  sticky_q <= 1'b0;
                  state    <= SHIFT;
               end
            end
            SHIFT: begin
               mag_q    <= mag_n;
               guard_q  <= guard_n;
               sticky_q <= sticky_n;
               count_q  <= count_q - amt;
               if (count_q <= STEP)
                  state <= ROUND;
            end
            ROUND: begin
               r_q    <= rnd_r;
               neg_q  <= rnd_neg;
               cout_q <= rnd_cout;
               ovf_q  <= rnd_ovf;
               zero_q <= rnd_zero;
               state  <= DONE;
            end
            DONE: begin
               if (out_ready)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign r         = r_q;
   assign negative  = neg_q;
   assign cout      = cout_q;
   assign overflow  = ovf_q;
   assign zero      = zero_q;

endmodule
